pattern_bit_sequencer: RTL and testbench
========================================

Name: pattern_bit_sequencer

Overview:
- Parametrised, programmable bit-serial pattern generator.
- An up/down counter walks the bit positions of one memory word selected by `address`, and emits one bit per enabled cycle.
- Adds the following:
  - runtime write port
  - programmable wrap limit
  - count direction
  - one-shot mode with a done state
  - registered output with valid and wrap strobes
- Sits between the control/sequencing logic and any serial consumer (LED/shift/test-pattern paths).

Parameters:
- SEL_W, 3: counter width; the word width is WORD_W = 2**SEL_W bits.
- ADDR_W, 3: memory address width; depth is 2**ADDR_W words.
- INVERT, 1: 1 means `out` is the inverted selected bit (legacy polarity); 0 means the true bit.

Ports:
- `clock`  in  1  single clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run/step request.
- `dir`  in  1  count direction: 0 = up, 1 = down.
- `oneshot`  in  1  1 = stop at the terminal count (DONE); 0 = wrap continuously.
- `limit`  in  SEL_W  terminal bit index.
- `address`  in  ADDR_W  read word select.
- `wr_en`  in  1  memory write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  WORD_W  write data.
- `out`  out  1  registered pattern bit.
- `out_valid`  out  1  `out` holds a fresh sample this cycle.
- `wrap`  out  1  1-cycle pulse, aligned with the sample taken at the terminal count.
- `done`  out  1  high while in DONE.
- `count`  out  SEL_W  current bit index.

Behaviour:
- Reset (`clear`=1, asynchronous):
  - State goes to IDLE.
  - `count`=0, `out`=0, `out_valid`=0, `wrap`=0, `done`=0.
  - Memory is not cleared. It keeps its initial or written contents.
- Memory initial contents: word i = low min(i+1, WORD_W) bits set. For the defaults: 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF.
- Memory write: synchronous on `wr_en`. Read is asynchronous with read-before-write: a same-cycle write to `address` is not visible until the next cycle.
- Start value: 0 when `dir`=0, `limit` when `dir`=1. Terminal value: `limit` when `dir`=0, 0 when `dir`=1.
- IDLE:
  - `count` loads the start value every cycle.
  - `enable`=1 moves to RUN. No sample is taken in this cycle.
- RUN, `enable`=1, per cycle:
  - Sample `bit = mem[address][count] ^ INVERT`.
  - Next cycle: `out`=`bit`, `out_valid`=1.
  - If `count` is the terminal value: `wrap`=1 next cycle. Then, if `oneshot`=1, go to DONE with `count` frozen; otherwise `count` loads the start value.
  - Else if `dir`=0 and `count` > `limit` (limit lowered mid-run): `count` goes to 0 and `wrap` pulses.
  - Otherwise `count` steps by ±1 according to `dir`.
- RUN, `enable`=0: pause. `count` holds, `out` holds, `out_valid`=0 and `wrap`=0 next cycle. State stays RUN.
- DONE:
  - `done`=1, `count` frozen, `out_valid`=0.
  - `enable`=0 moves to IDLE.
- Latency: `out` reflects `address` and `count` as sampled one clock earlier.
- Direction/limit changes:
  - A change to `dir` takes effect on the next step.
  - In down mode with `count` > `limit`, `count` steps down normally.
- `wrap` and `out_valid` are never asserted in the same cycle as `clear`.
- All counter arithmetic is modulo 2**SEL_W.
- `limit`=0 makes every enabled cycle a terminal cycle.

Decomposition:
- Shared package/include `pattern_seq_pkg` holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - DIR_UP=1'b0 and DIR_DOWN=1'b1
  - the init-pattern function
- Sub-module `pattern_mem`: ADDR_W/WORD_W-parametrised, initialised, with synchronous write and asynchronous read.
- The counter, FSM and output register live in the top module.

Test Plan:
1. Legacy loop: `clear` pulse; `enable`=1, `dir`=0, `limit`=7, `oneshot`=0, `address`=3 (0x0F), INVERT=1. Required: valid `out` = 0,0,0,0,1,1,1,1; `wrap` high with the 8th sample; the sequence repeats.
2. Down count: `dir`=1, `limit`=5, `address`=1 (0x03). Required: `count` goes 5..0 and `out` = 1,1,1,1,0,0; `wrap` on the last sample; then `count` reloads 5.
3. One-shot: `dir`=0, `limit`=2, `address`=7, `oneshot`=1. Required: `out` = 0,0,0 with `wrap` on the 3rd sample; then `done`=1, `count`=2 frozen, `out_valid`=0; dropping `enable` gives IDLE and `count`=0.
4. Write collision: `wr_en` to address 2 with 0xA5 while `address`=2 and `count`=1. Required: that sample uses 0x07 (`out`=0); later samples follow ~0xA5 bit by bit (bit2 gives `out`=0, bit3 gives `out`=1).
5. Pause and async clear: drop `enable` for 3 cycles at `count`=4. Required: `out_valid`=0 and `count` holds at 4; resume continues from 4. Then assert `clear` mid-cycle at `count`=6. Required: all outputs go to 0 immediately, state is IDLE, and word 2 still reads 0xA5.
6. Limit lowered: with `count`=6 running up, set `limit`=3. Required: next `count`=0 with a `wrap` pulse; `count` then cycles 0..3.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types, direction constants and power-up pattern helper
// for the bit-serial pattern sequencer.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MAX_WORD_W = 256;

  // Word idx powers up with its low min(idx+1, word_w) bits set.
  function automatic logic [MAX_WORD_W-1:0] init_word(int idx, int word_w);
    int n;
    n = (idx + 1 < word_w) ? idx + 1 : word_w;
    init_word = '0;
    for (int b = 0; b < MAX_WORD_W; b++) begin
      if (b < n) init_word[b] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/pattern_bit_sequencer_if.sv
// Control, write-port and serial-output bundle of the pattern sequencer.
// The master side drives controls and writes; the slave side is the sequencer.
interface pattern_bit_sequencer_if #(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 3
);
  localparam int WORD_W = 2 ** SEL_W;

  logic              enable;
  logic              dir;
  logic              oneshot;
  logic [SEL_W-1:0]  limit;
  logic [ADDR_W-1:0] address;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              out;
  logic              out_valid;
  logic              wrap;
  logic              done;
  logic [SEL_W-1:0]  count;

  modport master (
    output enable, dir, oneshot, limit, address, wr_en, wr_addr, wr_data,
    input  out, out_valid, wrap, done, count
  );

  modport slave (
    input  enable, dir, oneshot, limit, address, wr_en, wr_addr, wr_data,
    output out, out_valid, wrap, done, count
  );

endinterface

// File: rtl/pattern_mem.sv
// Pattern word store: power-up image, synchronous write, asynchronous read.
// Storage is never reset so patterns survive a sequencer clear.
module pattern_mem
  import pattern_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 8
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] words [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [MAX_WORD_W-1:0] INIT_FULL = init_word(i, WORD_W);
    logic [WORD_W-1:0] word_q = INIT_FULL[WORD_W-1:0];

    always @(posedge clock) begin
      if (wr_en && wr_addr == ADDR_W'(i)) word_q <= wr_data;
    end

    assign words[i] = word_q;
  end

  // Read is combinational, so a same-cycle write shows up one cycle later.
  assign rd_data = words[rd_addr];

endmodule

// File: rtl/pattern_bit_sequencer.sv
// Bit-serial pattern generator: walks the bits of one stored word with an
// up/down counter and emits one registered bit per enabled cycle.
//
//   state | meaning
//   IDLE  | counter parked at start value, waiting for enable
//   RUN   | sampling one bit per enabled cycle, pausing when enable is low
//   DONE  | one-shot finished, counter frozen until enable drops
module pattern_bit_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 3,
  parameter int INVERT = 1
) (
  input logic                  clock,
  input logic                  clear,
  pattern_bit_sequencer_if.slave bus
);
  localparam int   WORD_W = 2 ** SEL_W;
  localparam logic INV    = (INVERT != 0);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  count_q, count_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [WORD_W-1:0] rd_word;
  logic [SEL_W-1:0]  start_val;
  logic [SEL_W-1:0]  term_val;

  pattern_mem #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (bus.address),
    .rd_data (rd_word)
  );

  assign start_val = (bus.dir == DIR_DOWN) ? bus.limit : '0;
  assign term_val  = (bus.dir == DIR_DOWN) ? '0 : bus.limit;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = start_val;
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (bus.enable) begin
          out_d   = rd_word[count_q] ^ INV;
          valid_d = 1'b1;
          if (count_q == term_val) begin
            wrap_d = 1'b1;
            if (bus.oneshot) state_d = DONE;
            else             count_d = start_val;
          end else if (bus.dir == DIR_UP && count_q > bus.limit) begin
            // limit was lowered below the running count: restart the lap
            count_d = '0;
            wrap_d  = 1'b1;
          end else if (bus.dir == DIR_DOWN) begin
            count_d = count_q - SEL_W'(1);
          end else begin
            count_d = count_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pattern_bit_sequencer.sv
// Directed bench for pattern_bit_sequencer: a cycle model derived from the
// behavioural rules is compared every cycle, plus literal sequence checks.
module tb_pattern_bit_sequencer;
  localparam int SEL_W  = 3;
  localparam int ADDR_W = 3;
  localparam int NBITS  = 8;

  logic clock = 1'b0;
  logic clear = 1'b0;

  pattern_bit_sequencer_if #(.SEL_W(SEL_W), .ADDR_W(ADDR_W)) bus ();

  pattern_bit_sequencer #(
    .SEL_W  (SEL_W),
    .ADDR_W (ADDR_W),
    .INVERT (1)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: mode 0 = parked, 1 = stepping, 2 = finished one-shot
  int         m_mode  = 0;
  int         m_count = 0;
  bit         m_out   = 0;
  bit         m_valid = 0;
  bit         m_wrap  = 0;
  logic [7:0] m_mem [8];

  task automatic model_step();
    int start, term;
    if (clear) begin
      m_mode = 0; m_count = 0; m_out = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    start   = bus.dir ? int'(bus.limit) : 0;
    term    = bus.dir ? 0 : int'(bus.limit);
    m_valid = 0;
    m_wrap  = 0;
    if (m_mode == 0) begin
      m_count = start;
      if (bus.enable) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.enable) begin
        m_out   = !((m_mem[bus.address] >> m_count) & 8'd1);
        m_valid = 1;
        if (m_count == term) begin
          m_wrap = 1;
          if (bus.oneshot) m_mode = 2;
          else             m_count = start;
        end else if (!bus.dir && m_count > int'(bus.limit)) begin
          m_count = 0;
          m_wrap  = 1;
        end else begin
          m_count = (m_count + (bus.dir ? NBITS - 1 : 1)) % NBITS;
        end
      end
    end else begin
      if (!bus.enable) m_mode = 0;
    end
    if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 8'((1 << (i + 1)) - 1);
    forever begin
      @(posedge clock or posedge clear);
      model_step();
    end
  end

  bit q_out[$];
  bit q_wrap[$];
  int q_cnt[$];

  initial begin
    forever begin
      @(posedge clock);
      #1;
      chk("cyc_out",   bus.out,       m_out);
      chk("cyc_valid", bus.out_valid, m_valid);
      chk("cyc_wrap",  bus.wrap,      m_wrap);
      chk("cyc_done",  bus.done,      (m_mode == 2));
      chk("cyc_count", bus.count,     m_count);
      if (bus.out_valid === 1'b1) begin
        q_out.push_back(bus.out);
        q_wrap.push_back(bus.wrap);
        q_cnt.push_back(int'(bus.count));
      end
    end
  end

  task automatic edges(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic flush_q();
    q_out.delete(); q_wrap.delete(); q_cnt.delete();
  endtask

  task automatic check_q(string name, int n, logic [15:0] exp_out, logic [15:0] exp_wrap);
    chk({name, "_len"}, q_out.size(), n);
    for (int i = 0; i < n && i < q_out.size(); i++) begin
      chk($sformatf("%s_out%0d", name, i), q_out[i], exp_out[i]);
      chk($sformatf("%s_wrap%0d", name, i), q_wrap[i], exp_wrap[i]);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    flush_q();
  endtask

  initial begin
    bus.enable = 0; bus.dir = 0; bus.oneshot = 0; bus.limit = 3'd7;
    bus.address = 3'd3; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    #1 clear = 1'b1;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_out",   bus.out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_wrap",  bus.wrap, 0);
    chk("rst_done",  bus.done, 0);

    // legacy loop over 0x0F, two full laps
    @(negedge clock);
    clear = 1'b0;
    bus.enable = 1;
    flush_q();
    edges(17);
    check_q("loop", 16, 16'hF0F0, 16'h8080);

    // down count over 0x03 from 5
    pulse_clear();
    bus.dir = 1; bus.limit = 3'd5; bus.address = 3'd1;
    edges(7);
    check_q("down", 6, 16'h000F, 16'h0020);
    chk("down_reload", bus.count, 5);

    // one-shot over 0xFF, limit 2
    pulse_clear();
    bus.dir = 0; bus.limit = 3'd2; bus.address = 3'd7; bus.oneshot = 1;
    edges(5);
    check_q("oneshot", 3, 16'h0000, 16'h0004);
    chk("os_done",  bus.done, 1);
    chk("os_count", bus.count, 2);
    chk("os_valid", bus.out_valid, 0);
    bus.enable = 0;
    edges(2);
    chk("os_idle_count", bus.count, 0);
    chk("os_idle_done",  bus.done, 0);

    // write collision on the word being read
    pulse_clear();
    bus.oneshot = 0; bus.limit = 3'd7; bus.address = 3'd2; bus.enable = 1;
    edges(2);
    bus.wr_en = 1; bus.wr_addr = 3'd2; bus.wr_data = 8'hA5;
    edges(1);
    bus.wr_en = 0;
    edges(2);
    check_q("wrcol", 4, 16'h0008, 16'h0000);
    chk("wrcol_count", bus.count, 4);

    // pause, resume, then asynchronous clear mid-cycle
    bus.enable = 0;
    flush_q();
    edges(3);
    chk("pause_samples", q_out.size(), 0);
    chk("pause_count", bus.count, 4);
    chk("pause_valid", bus.out_valid, 0);
    chk("pause_out",   bus.out, 1);
    bus.enable = 1;
    edges(2);
    check_q("resume", 2, 16'h0001, 16'h0000);
    chk("resume_count", bus.count, 6);
    #2 clear = 1'b1;
    #1;
    chk("aclr_out",   bus.out, 0);
    chk("aclr_valid", bus.out_valid, 0);
    chk("aclr_wrap",  bus.wrap, 0);
    chk("aclr_done",  bus.done, 0);
    chk("aclr_count", bus.count, 0);
    @(negedge clock);
    clear = 1'b0;
    flush_q();
    edges(9);
    check_q("keepmem", 8, 16'h005A, 16'h0080);

    // limit lowered below the running count
    edges(6);
    chk("pre_lim_count", bus.count, 6);
    bus.limit = 3'd3;
    flush_q();
    edges(9);
    check_q("lowlim", 9, 16'h0155, 16'h0111);
    for (int i = 0; i < 9 && i < q_cnt.size(); i++)
      chk($sformatf("lowlim_cnt%0d", i), q_cnt[i], i % 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
